// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_pkg
//  Description : Shared types and encodings for the data-memory arbiter:
//                FSM states, owner identifiers and rw_type (func3) codes.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,     // ready to issue
        ST_WAIT = 2'd1,     // read in flight
        ST_DONE = 2'd2      // read data returned, completion cycle
    } state_t;

    // Owner / grant identifiers (also the bit index into the request vector)
    localparam logic c_OWNER_CORE = 1'b0;
    localparam logic c_OWNER_EXT  = 1'b1;

    // rw_type encodings (func3); passed through untouched to the RAM wrapper
    localparam logic [2:0] c_RW_LB  = 3'b000;
    localparam logic [2:0] c_RW_LH  = 3'b001;
    localparam logic [2:0] c_RW_LW  = 3'b010;
    localparam logic [2:0] c_RW_LBU = 3'b100;
    localparam logic [2:0] c_RW_LHU = 3'b101;
    localparam logic [2:0] c_RW_SB  = 3'b000;
    localparam logic [2:0] c_RW_SH  = 3'b001;
    localparam logic [2:0] c_RW_SW  = 3'b010;

endpackage : dmem_arbiter_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin picker. Bit 0 = core, bit 1 = external.
//                On a tie the requester that was not granted last wins.
//                Purely combinational; the caller owns the 'last' register.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt_onehot
);

    // Single requester passes straight through; a tie goes to the other side of 'last'
    always_comb begin
        gnt_onehot = req;
        if (req == 2'b11) begin
            gnt_onehot = (last == c_OWNER_EXT) ? 2'b01 : 2'b10;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single data-RAM port between the core load/store
//                port and an external master (loader / DMA). Round-robin,
//                one transaction at a time, fixed RAM read latency.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    // core load/store port
    input  logic              core_r_en,
    input  logic              core_w_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [2:0]        core_rw_type,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    // external master port
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic [2:0]        ext_rw_type,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    // RAM port
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_rw_type,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Zero latency means the read completes in the issue cycle itself.
    localparam logic       c_COMB_READ = (READ_LAT == 0);
    // Number of WAIT cycles between issue and DONE, so that DONE lands exactly
    // READ_LAT cycles after mem_r_en (LAT=1 goes straight to DONE).
    localparam logic [2:0] c_LAT_M1    = (READ_LAT > 0) ? 3'(READ_LAT - 1) : 3'd0;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic              r_owner, w_owner_nxt;
    logic              r_last, w_last_nxt;
    logic [DATA_W-1:0] r_core_rdata, r_ext_rdata;

    logic              w_core_req;
    logic [1:0]        w_gnt;
    logic              w_we;
    logic              w_core_cap;
    logic              w_ext_cap;

    assign w_core_req = core_r_en | core_w_en;

    rr_arb2 u_arb (
        .req        ({ext_req, w_core_req}),
        .last       (r_last),
        .gnt_onehot (w_gnt)
    );

    // Next-state, RAM strobes/muxes and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_we        = 1'b0;
        w_core_cap  = 1'b0;
        w_ext_cap   = 1'b0;
        mem_r_en    = 1'b0;
        mem_w_en    = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_rw_type = 3'b000;
        core_stall  = w_core_req;   // any pending core access stalls unless it completes now
        ext_gnt     = 1'b0;
        ext_rvalid  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Nothing may reach the RAM while reset is asserted
                if (rst_n && (w_gnt != 2'b00)) begin
                    if (w_gnt[1]) begin
                        w_last_nxt  = c_OWNER_EXT;
                        ext_gnt     = 1'b1;
                        w_we        = ext_we;
                        mem_addr    = ext_addr;
                        mem_wdata   = ext_wdata;
                        mem_rw_type = ext_rw_type;
                    end else begin
                        w_last_nxt  = c_OWNER_CORE;
                        w_we        = core_w_en;    // r_en & w_en together acts as a write
                        mem_addr    = core_addr;
                        mem_wdata   = core_wdata;
                        mem_rw_type = core_rw_type;
                    end

                    if (w_we) begin
                        // Writes finish in the issue cycle
                        mem_w_en = 1'b1;
                        if (!w_gnt[1]) begin
                            core_stall = 1'b0;
                        end
                    end else begin
                        mem_r_en = 1'b1;
                        if (c_COMB_READ) begin
                            if (w_gnt[1]) begin
                                ext_rvalid = 1'b1;
                                w_ext_cap  = 1'b1;
                            end else begin
                                core_stall = 1'b0;
                                w_core_cap = 1'b1;
                            end
                        end else begin
                            w_owner_nxt = w_gnt[1] ? c_OWNER_EXT : c_OWNER_CORE;
                            w_cnt_nxt   = c_LAT_M1;
                            w_state_nxt = (c_LAT_M1 == 3'd0) ? ST_DONE : ST_WAIT;
                        end
                    end
                end
            end

            ST_WAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                // Data is on mem_rdata now; no new issue in this cycle
                w_state_nxt = ST_IDLE;
                if (r_owner == c_OWNER_CORE) begin
                    core_stall = 1'b0;
                    w_core_cap = 1'b1;
                end else begin
                    ext_rvalid = 1'b1;
                    w_ext_cap  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read data is forwarded in the completion cycle and held afterwards
    assign core_rdata = w_core_cap ? mem_rdata : r_core_rdata;
    assign ext_rdata  = w_ext_cap  ? mem_rdata : r_ext_rdata;

    // State, latency counter, owner, round-robin history and read-data holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 3'd0;
            r_owner      <= c_OWNER_CORE;
            r_last       <= c_OWNER_EXT;
            r_core_rdata <= '0;
            r_ext_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            if (w_core_cap) begin
                r_core_rdata <= mem_rdata;
            end
            if (w_ext_cap) begin
                r_ext_rdata <= mem_rdata;
            end
        end
    end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. Three instances with
//                READ_LAT = 1, 0, 3 each drive a simple RAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_r_en   [3];
    logic        core_w_en   [3];
    logic [31:0] core_addr   [3];
    logic [31:0] core_wdata  [3];
    logic [2:0]  core_rw_type[3];
    logic [31:0] core_rdata  [3];
    logic        core_stall  [3];
    logic        ext_req     [3];
    logic        ext_we      [3];
    logic [31:0] ext_addr    [3];
    logic [31:0] ext_wdata   [3];
    logic [2:0]  ext_rw_type [3];
    logic        ext_gnt     [3];
    logic        ext_rvalid  [3];
    logic [31:0] ext_rdata   [3];
    logic        mem_r_en    [3];
    logic        mem_w_en    [3];
    logic [31:0] mem_addr    [3];
    logic [31:0] mem_wdata   [3];
    logic [2:0]  mem_rw_type [3];
    logic [31:0] mem_rdata   [3];

    logic [31:0] ram  [3][64];
    logic [31:0] pipe [3][8];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(lat_of(g))) u_dut (
            .clk(clk), .rst_n(rst_n),
            .core_r_en(core_r_en[g]), .core_w_en(core_w_en[g]), .core_addr(core_addr[g]),
            .core_wdata(core_wdata[g]), .core_rw_type(core_rw_type[g]),
            .core_rdata(core_rdata[g]), .core_stall(core_stall[g]),
            .ext_req(ext_req[g]), .ext_we(ext_we[g]), .ext_addr(ext_addr[g]),
            .ext_wdata(ext_wdata[g]), .ext_rw_type(ext_rw_type[g]),
            .ext_gnt(ext_gnt[g]), .ext_rvalid(ext_rvalid[g]), .ext_rdata(ext_rdata[g]),
            .mem_r_en(mem_r_en[g]), .mem_w_en(mem_w_en[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rw_type(mem_rw_type[g]), .mem_rdata(mem_rdata[g])
        );
        if (lat_of(g) == 0) begin : g_comb_ram
            assign mem_rdata[g] = ram[g][mem_addr[g][7:2]];
        end else begin : g_pipe_ram
            assign mem_rdata[g] = pipe[g][lat_of(g)-1];
        end
    end

    // RAM model: writes on strobe; read data appears exactly READ_LAT cycles later,
    // otherwise a marker value so mistimed captures show up
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mem_w_en[i]) ram[i][mem_addr[i][7:2]] <= mem_wdata[i];
            pipe[i][0] <= mem_r_en[i] ? ram[i][mem_addr[i][7:2]] : 32'hBADDA7A0;
            for (int k = 1; k < 8; k++) pipe[i][k] <= pipe[i][k-1];
        end
    end

    // The core must never request load and store together
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            assert (!(core_r_en[i] && core_w_en[i])) else $error("FAIL core_r_en and core_w_en both set on dut %0d", i);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic core_access(input int d, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] rwt,
                               output logic [31:0] rdata, output int stalls, output logic ok);
        core_addr[d] = addr; core_wdata[d] = wdata; core_rw_type[d] = rwt;
        core_w_en[d] = we;   core_r_en[d] = !we;
        stalls = 0; ok = 1'b0; rdata = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (core_stall[d] === 1'b0) begin
                ok = 1'b1; rdata = core_rdata[d];
                break;
            end
            stalls++;
        end
        tick();
        core_r_en[d] = 1'b0; core_w_en[d] = 1'b0;
    endtask

    task automatic ext_access(input int d, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output int waits, output int lat, output logic ok);
        ext_addr[d] = addr; ext_wdata[d] = wdata; ext_rw_type[d] = we ? c_RW_SW : c_RW_LW;
        ext_we[d] = we; ext_req[d] = 1'b1;
        waits = 0; lat = -1; ok = 1'b0; rdata = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ext_gnt[d] === 1'b1) begin
                ok = 1'b1;
                if (ext_rvalid[d] === 1'b1) begin lat = 0; rdata = ext_rdata[d]; end
                break;
            end
            waits++;
        end
        tick();
        ext_req[d] = 1'b0;
        if (ok && !we && lat < 0) begin
            for (int c = 1; c < 20; c++) begin
                @(negedge clk);
                if (ext_rvalid[d] === 1'b1) begin lat = c; rdata = ext_rdata[d]; break; end
            end
            tick();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({core_stall[d], ext_gnt[d], ext_rvalid[d], mem_r_en[d], mem_w_en[d]} !== 5'b0) begin
                n_errors++;
                $display("FAIL reset_strobes dut%0d: stall/gnt/rvalid/r_en/w_en=%b required 00000", d,
                         {core_stall[d], ext_gnt[d], ext_rvalid[d], mem_r_en[d], mem_w_en[d]});
            end
            n_checks++;
            if ({mem_addr[d], mem_wdata[d], core_rdata[d], ext_rdata[d]} !== 128'd0) begin
                n_errors++;
                $display("FAIL reset_buses dut%0d: addr=%h wdata=%h core_rdata=%h ext_rdata=%h required all 0",
                         d, mem_addr[d], mem_wdata[d], core_rdata[d], ext_rdata[d]);
            end
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_core_store();
        core_addr[0] = 32'h10; core_wdata[0] = 32'hDEADBEEF; core_rw_type[0] = c_RW_SW; core_w_en[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_w_en[0], mem_r_en[0], core_stall[0]} !== 3'b100) begin
            n_errors++;
            $display("FAIL store_issue: w_en/r_en/stall=%b required 100", {mem_w_en[0], mem_r_en[0], core_stall[0]});
        end
        n_checks++;
        if ({mem_addr[0], mem_wdata[0], mem_rw_type[0]} !== {32'h10, 32'hDEADBEEF, c_RW_SW}) begin
            n_errors++;
            $display("FAIL store_bus: addr=%h wdata=%h type=%b required 00000010 deadbeef 010",
                     mem_addr[0], mem_wdata[0], mem_rw_type[0]);
        end
        tick();
        core_w_en[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_w_en[0], core_stall[0]} !== 2'b00) begin
            n_errors++;
            $display("FAIL store_no_extra: w_en/stall=%b required 00", {mem_w_en[0], core_stall[0]});
        end
        tick();
    endtask

    task automatic test_core_load();
        logic [31:0] rd; int st; logic ok;
        core_access(0, 1'b0, 32'h10, 32'h0, c_RW_LW, rd, st, ok);
        n_checks++;
        if (!ok || st != 1 || rd !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL core_load: done=%0b stalls=%0d data=%h required 1 1 deadbeef", ok, st, rd);
        end
        @(negedge clk);
        n_checks++;
        if (core_rdata[0] !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL core_rdata_hold: %h required deadbeef", core_rdata[0]);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [31:0] rd; int st; logic ok;
        core_access(0, 1'b1, 32'h20, 32'hC0FFEE01, c_RW_SW, rd, st, ok);
        core_access(0, 1'b1, 32'h24, 32'hC0FFEE02, c_RW_SW, rd, st, ok);
        apply_reset();
        core_addr[0] = 32'h24; core_rw_type[0] = c_RW_LW; core_r_en[0] = 1'b1;
        ext_addr[0] = 32'h20; ext_rw_type[0] = c_RW_LW; ext_we[0] = 1'b0; ext_req[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_r_en[0], core_stall[0], ext_gnt[0]} !== 3'b110 || mem_addr[0] !== 32'h24) begin
            n_errors++;
            $display("FAIL tie_core_first: r_en/stall/gnt=%b addr=%h required 110 00000024",
                     {mem_r_en[0], core_stall[0], ext_gnt[0]}, mem_addr[0]);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({core_stall[0], ext_gnt[0]} !== 2'b00 || core_rdata[0] !== 32'hC0FFEE02) begin
            n_errors++;
            $display("FAIL tie_core_done: stall/gnt=%b data=%h required 00 c0ffee02",
                     {core_stall[0], ext_gnt[0]}, core_rdata[0]);
        end
        tick();
        core_r_en[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ext_gnt[0], mem_r_en[0]} !== 2'b11 || mem_addr[0] !== 32'h20) begin
            n_errors++;
            $display("FAIL tie_ext_gnt: gnt/r_en=%b addr=%h required 11 00000020", {ext_gnt[0], mem_r_en[0]}, mem_addr[0]);
        end
        tick();
        ext_req[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ext_rvalid[0] !== 1'b1 || ext_rdata[0] !== 32'hC0FFEE01) begin
            n_errors++;
            $display("FAIL tie_ext_rvalid: rvalid=%b data=%h required 1 c0ffee01", ext_rvalid[0], ext_rdata[0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int ci; int ei; logic cg; logic eg; logic exp_core; logic [31:0] exp_addr;
        apply_reset();
        ci = 0; ei = 0;
        core_addr[0] = 32'h100; core_wdata[0] = 32'h11110000; core_rw_type[0] = c_RW_SW; core_w_en[0] = 1'b1;
        ext_addr[0]  = 32'h200; ext_wdata[0]  = 32'h22220000; ext_we[0] = 1'b1; ext_rw_type[0] = c_RW_SW; ext_req[0] = 1'b1;
        for (int r = 0; r < 4; r++) begin
            exp_core = (r % 2 == 0);
            exp_addr = exp_core ? 32'h100 + 32'(4 * ci) : 32'h200 + 32'(4 * ei);
            @(negedge clk);
            cg = (core_stall[0] === 1'b0);
            eg = (ext_gnt[0] === 1'b1);
            n_checks++;
            if ({cg, eg} !== {exp_core, !exp_core} || mem_addr[0] !== exp_addr || mem_w_en[0] !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b_grant%0d: core/ext granted=%b%b addr=%h w_en=%b required %b%b %h 1",
                         r, cg, eg, mem_addr[0], mem_w_en[0], exp_core, !exp_core, exp_addr);
            end
            tick();
            if (cg) begin ci++; core_addr[0] = 32'h100 + 32'(4 * ci); end
            if (eg) begin ei++; ext_addr[0]  = 32'h200 + 32'(4 * ei); end
        end
        core_w_en[0] = 1'b0; ext_req[0] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] rd; int st; logic ok; int seen;
        core_access(2, 1'b1, 32'h30, 32'h5A5A1234, c_RW_SW, rd, st, ok);
        ext_addr[2] = 32'h40; ext_we[2] = 1'b0; ext_rw_type[2] = c_RW_LW; ext_req[2] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ext_gnt[2] !== 1'b1) begin
            n_errors++;
            $display("FAIL midread_gnt: gnt=%b required 1", ext_gnt[2]);
        end
        tick();
        ext_req[2] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ext_rvalid[2], ext_gnt[2], mem_r_en[2], mem_w_en[2]} !== 4'b0) begin
            n_errors++;
            $display("FAIL midread_in_reset: rvalid/gnt/r_en/w_en=%b required 0000",
                     {ext_rvalid[2], ext_gnt[2], mem_r_en[2], mem_w_en[2]});
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ext_rvalid[2] === 1'b1 || mem_r_en[2] === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_errors++;
            $display("FAIL midread_discard: stray rvalid/r_en cycles=%0d required 0", seen);
        end
        tick();
        core_access(2, 1'b0, 32'h30, 32'h0, c_RW_LW, rd, st, ok);
        n_checks++;
        if (!ok || st != 3 || rd !== 32'h5A5A1234) begin
            n_errors++;
            $display("FAIL midread_recover: done=%0b stalls=%0d data=%h required 1 3 5a5a1234", ok, st, rd);
        end
    endtask

    task automatic test_lat_sweep();
        logic [31:0] rd; logic [31:0] val; logic [31:0] addr; int st; int wt; int lt; logic ok;
        for (int d = 1; d < 3; d++) begin
            for (int rep = 0; rep < 2; rep++) begin
                addr = 32'(4 * $urandom_range(0, 31));
                val  = $urandom;
                core_access(d, 1'b1, addr, val, c_RW_SW, rd, st, ok);
                n_checks++;
                if (!ok || st != 0) begin
                    n_errors++;
                    $display("FAIL sweep_store lat%0d: done=%0b stalls=%0d required 1 0", lat_of(d), ok, st);
                end
                core_access(d, 1'b0, addr, 32'h0, c_RW_LW, rd, st, ok);
                n_checks++;
                if (!ok || st != lat_of(d) || rd !== val) begin
                    n_errors++;
                    $display("FAIL sweep_load lat%0d: done=%0b stalls=%0d data=%h required 1 %0d %h",
                             lat_of(d), ok, st, rd, lat_of(d), val);
                end
                ext_access(d, 1'b0, addr, 32'h0, rd, wt, lt, ok);
                n_checks++;
                if (!ok || wt != 0 || lt != lat_of(d) || rd !== val) begin
                    n_errors++;
                    $display("FAIL sweep_ext lat%0d: gnt=%0b waits=%0d rvalid_lat=%0d data=%h required 1 0 %0d %h",
                             lat_of(d), ok, wt, lt, rd, lat_of(d), val);
                end
            end
        end
    endtask

    // Both masters hammer disjoint halves of the RAM; each read must return that
    // master's own last write, and neither may wait longer than one foreign transaction.
    task automatic test_random();
        logic [31:0] ref_mem [64];
        bit          ref_ok  [64];
        for (int i = 0; i < 64; i++) ref_ok[i] = 1'b0;
        fork
            begin
                logic [31:0] rd; logic [31:0] v; int st; logic ok; logic we; int idx; int nv;
                nv = 0;
                for (int n = 0; n < 25; n++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    idx = $urandom_range(0, 31);
                    we  = (nv == 0) || ($urandom_range(0, 1) == 1);
                    if (!we && !ref_ok[idx]) we = 1'b1;
                    v = $urandom;
                    core_access(0, we, 32'(idx * 4), v, we ? c_RW_SW : c_RW_LW, rd, st, ok);
                    n_checks++;
                    if (!ok || st > 2 * lat_of(0) + 1 || (!we && rd !== ref_mem[idx])) begin
                        n_errors++;
                        $display("FAIL rand_core op%0d we=%0b addr=%h: done=%0b stalls=%0d data=%h required 1 <=3 %h",
                                 n, we, idx * 4, ok, st, rd, ref_mem[idx]);
                    end
                    if (we) begin ref_mem[idx] = v; ref_ok[idx] = 1'b1; nv++; end
                end
            end
            begin
                logic [31:0] rd; logic [31:0] v; int wt; int lt; logic ok; logic we; int idx; int nv;
                nv = 0;
                for (int n = 0; n < 25; n++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    idx = $urandom_range(32, 63);
                    we  = (nv == 0) || ($urandom_range(0, 1) == 1);
                    if (!we && !ref_ok[idx]) we = 1'b1;
                    v = $urandom;
                    ext_access(0, we, 32'(idx * 4), v, rd, wt, lt, ok);
                    n_checks++;
                    if (!ok || wt > lat_of(0) + 1 || (!we && (lt != lat_of(0) || rd !== ref_mem[idx]))) begin
                        n_errors++;
                        $display("FAIL rand_ext op%0d we=%0b addr=%h: gnt=%0b waits=%0d lat=%0d data=%h required 1 <=2 1 %h",
                                 n, we, idx * 4, ok, wt, lt, rd, ref_mem[idx]);
                    end
                    if (we) begin ref_mem[idx] = v; ref_ok[idx] = 1'b1; nv++; end
                end
            end
        join
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            core_r_en[d] = 1'b0; core_w_en[d] = 1'b0; core_addr[d] = '0; core_wdata[d] = '0;
            core_rw_type[d] = 3'b000; ext_req[d] = 1'b0; ext_we[d] = 1'b0; ext_addr[d] = '0;
            ext_wdata[d] = '0; ext_rw_type[d] = 3'b000;
        end
        tick();
        test_reset();
        test_core_store();
        test_core_load();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        test_lat_sweep();
        test_random();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
